// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the pipelined extended-Hamming SECDED codec.
//   - APB register word indices (PADDR[4:2])
//   - MODE and err_num encodings
//   - constant functions: parity-bit count m(N), data-bit count K(N),
//     Hamming position of each data bit, parity coverage mask per parity bit
package ecc_pkg;

  // Register word indices decoded from PADDR[4:2]
  localparam logic [2:0] REG_CTRL    = 3'd0;  // 0x00
  localparam logic [2:0] REG_DATA_IN = 3'd1;  // 0x04
  localparam logic [2:0] REG_NOISE   = 3'd2;  // 0x08
  localparam logic [2:0] REG_STATUS  = 3'd3;  // 0x0C
  localparam logic [2:0] REG_CNT1    = 3'd4;  // 0x10
  localparam logic [2:0] REG_CNT2    = 3'd5;  // 0x14

  typedef enum logic [1:0] {
    MODE_ENC  = 2'd0,
    MODE_DEC  = 2'd1,
    MODE_FULL = 2'd2,
    MODE_RSVD = 2'd3
  } ecc_mode_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_SINGLE = 2'd1,
    ERR_DOUBLE = 2'd2
  } ecc_err_e;

  // Number of Hamming parity bits (excluding the overall-parity bit)
  function automatic int ecc_m(input int n);
    return $clog2(n);
  endfunction

  // Number of data bits carried by an N-bit codeword
  function automatic int ecc_k(input int n);
    return n - $clog2(n) - 1;
  endfunction

  // Hamming position of data bit i: the i-th position that is not a power
  // of two (3, 5, 6, 7, 9, ...)
  function automatic int ecc_data_pos(input int i);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 3; p < 64; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == i) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

  // Data bits covered by parity bit j: those whose position has bit j set
  function automatic logic [31:0] ecc_cov_mask(input int n, input int j);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < ecc_k(n) && ((ecc_data_pos(i) >> j) & 1) == 1) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/ecc_enc_dec_pipe_if.sv
// ecc_enc_dec_pipe_if: APB slave bus bundle for the ECC codec.
//   PADDR   - address (only bits [4:2] decoded by the codec)
//   PWRITE  - write access
//   PSEL    - slave select
//   PENABLE - access phase
//   PWDATA  - write data
//   PRDATA  - read data (driven by the slave)
interface ecc_enc_dec_pipe_if #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20
);
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic                       PWRITE;
  logic                       PSEL;
  logic                       PENABLE;
  logic [AMBA_WORD-1:0]       PWDATA;
  logic [AMBA_WORD-1:0]       PRDATA;

  modport master (output PADDR, PWRITE, PSEL, PENABLE, PWDATA, input PRDATA);
  modport slave  (input PADDR, PWRITE, PSEL, PENABLE, PWDATA, output PRDATA);
endinterface

// File: rtl/ecc_sync_fifo.sv
// ecc_sync_fifo: single-clock FIFO for the codec input queue.
//   clk, rst     - clock, asynchronous active-low reset (empties the queue)
//   push         - push request; dropped when full unless a pop frees a slot
//   push_data    - word to enqueue
//   pop          - pop request; ignored when empty
//   head         - word at the head (meaningful when !empty)
//   full, empty  - occupancy flags
//   count        - number of stored words (0..DEPTH)
//   overflow     - one-cycle pulse when a push is dropped
// DEPTH must be a power of two so the pointers wrap naturally.
module ecc_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so push-while-full still lands.
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: contents are only visible through head when
  // count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ecc_enc_dec_pipe.sv
// ecc_enc_dec_pipe: pipelined extended-Hamming SECDED codec behind an APB slave.
//   clk            - clock, rising edge
//   rst            - asynchronous reset, active-low
//   apb            - APB slave port (ecc_enc_dec_pipe_if.slave)
//   data_out       - result word, zero-extended, held between done pulses
//   operation_done - one-cycle pulse per completed word
//   err_num        - 0 none, 1 single corrected, 2 double detected
// Registers: 0x00 CTRL {MODE[2:1], EN[0]}, 0x04 DATA_IN (push / head read),
// 0x08 NOISE, 0x0C STATUS {OVF, full, empty, count[4:0]}.
// Optional build macro ERR_STATS_EN adds 0x10 CNT1 / 0x14 CNT2 saturating
// error counters; without it those offsets read 0.
//
// Flow: a word enters the FIFO when a DATA_IN write commits and there is room
// (or a pop frees a slot the same cycle). It leaves the FIFO when EN=1 and the
// FIFO is non-empty. After that s1_valid -> operation_done is a stall-free
// valid chain: nothing back-pressures, so every popped word completes exactly
// two cycles after its pop.
module ecc_enc_dec_pipe
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int CODE_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ecc_enc_dec_pipe_if.slave    apb,
  output logic [AMBA_WORD-1:0] data_out,
  output logic                 operation_done,
  output logic [1:0]           err_num
);
  localparam int N  = CODE_WIDTH;
  localparam int M  = ecc_m(N);
  localparam int K  = ecc_k(N);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Systematic layout: [K-1:0] data, [K+M-1:K] parity, [N-1] overall parity
  function automatic logic [N-1:0] ecc_encode(input logic [K-1:0] d);
    logic [N-1:0] cw;
    cw        = '0;
    cw[K-1:0] = d;
    for (int j = 0; j < M; j++) cw[K+j] = ^(32'(d) & ecc_cov_mask(N, j));
    cw[N-1]   = ^cw[N-2:0];
    return cw;
  endfunction

  // Returns {err_num, data}. The syndrome equals the Hamming position of a
  // single flipped bit; only data positions need correcting for the output.
  function automatic logic [K+1:0] ecc_decode(input logic [N-1:0] cw);
    logic [K-1:0] d;
    logic [M-1:0] syn;
    logic         odd;
    ecc_err_e     err;
    d = cw[K-1:0];
    for (int j = 0; j < M; j++) syn[j] = cw[K+j] ^ (^(32'(d) & ecc_cov_mask(N, j)));
    odd = ^cw;
    if (odd) begin
      err = ERR_SINGLE;
      for (int i = 0; i < K; i++) begin
        if (int'(syn) == ecc_data_pos(i)) d[i] = ~d[i];
      end
    end else if (syn != '0) begin
      err = ERR_DOUBLE;
    end else begin
      err = ERR_NONE;
    end
    return {err, d};
  endfunction

  // APB decode
  logic [2:0] reg_idx;
  logic       apb_wr;
  logic       apb_rd;
  assign reg_idx = apb.PADDR[4:2];
  assign apb_wr  = apb.PSEL && apb.PENABLE && apb.PWRITE;
  assign apb_rd  = rst && apb.PSEL && !apb.PWRITE;

  // Configuration / status registers
  logic        ctrl_en;
  ecc_mode_e   ctrl_mode;
  logic [N-1:0] noise_q;
  logic        ovf;

  // FIFO
  logic          fifo_push;
  logic          fifo_pop;
  logic [N-1:0]  fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_ovf;

  assign fifo_push = apb_wr && (reg_idx == REG_DATA_IN);
  assign fifo_pop  = ctrl_en && !fifo_empty;

  ecc_sync_fifo #(
    .WIDTH (N),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (apb.PWDATA[N-1:0]),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_ovf)
  );

  // Reserved MODE behaves as encode; folding it here keeps stage 2 simple.
  ecc_mode_e mode_eff;
  always_comb begin
    mode_eff = ctrl_mode;
    if (ctrl_mode == MODE_RSVD) mode_eff = MODE_ENC;
  end

  // Pipeline state
  logic         s1_valid;
  ecc_mode_e    s1_mode;
  logic [N-1:0] s1_word;
  logic [K+1:0] dec_res;

  assign dec_res = ecc_decode(s1_word);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en        <= 1'b0;
      ctrl_mode      <= MODE_ENC;
      noise_q        <= '0;
      ovf            <= 1'b0;
      s1_valid       <= 1'b0;
      s1_mode        <= MODE_ENC;
      s1_word        <= '0;
      data_out       <= '0;
      operation_done <= 1'b0;
      err_num        <= ERR_NONE;
    end else begin
      if (apb_wr) begin
        case (reg_idx)
          REG_CTRL: begin
            ctrl_en   <= apb.PWDATA[0];
            ctrl_mode <= ecc_mode_e'(apb.PWDATA[2:1]);
          end
          REG_NOISE: noise_q <= apb.PWDATA[N-1:0];
          default: ;
        endcase
      end

      if (fifo_ovf) ovf <= 1'b1;
      else if (apb_wr && reg_idx == REG_STATUS) ovf <= 1'b0;

      // Stage 1: MODE and NOISE are captured with the word at pop time
      s1_valid <= fifo_pop;
      if (fifo_pop) begin
        s1_mode <= mode_eff;
        case (mode_eff)
          MODE_DEC:  s1_word <= fifo_head;
          MODE_FULL: s1_word <= ecc_encode(fifo_head[K-1:0]) ^ noise_q;
          default:   s1_word <= ecc_encode(fifo_head[K-1:0]);
        endcase
      end

      // Stage 2: decode and register outputs
      operation_done <= s1_valid;
      if (s1_valid) begin
        if (s1_mode == MODE_ENC) begin
          data_out <= AMBA_WORD'(s1_word);
          err_num  <= ERR_NONE;
        end else begin
          data_out <= AMBA_WORD'(dec_res[K-1:0]);
          err_num  <= dec_res[K+1:K];
        end
      end
    end
  end

`ifdef ERR_STATS_EN
  logic [15:0] cnt1;
  logic [15:0] cnt2;
  logic        stats_clr;
  assign stats_clr = apb_wr && (reg_idx == REG_CNT1 || reg_idx == REG_CNT2);

  // Counts follow the registered outputs; a clear in the same cycle wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else if (stats_clr) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else if (operation_done) begin
      if (err_num == ERR_SINGLE && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
      if (err_num == ERR_DOUBLE && cnt2 != 16'hFFFF) cnt2 <= cnt2 + 16'd1;
    end
  end
`endif

  // Read mux: combinational, zero outside a read or while in reset
  always_comb begin
    apb.PRDATA = '0;
    if (apb_rd) begin
      case (reg_idx)
        REG_CTRL:    apb.PRDATA = AMBA_WORD'({ctrl_mode, ctrl_en});
        REG_DATA_IN: if (!fifo_empty) apb.PRDATA = AMBA_WORD'(fifo_head);
        REG_NOISE:   apb.PRDATA = AMBA_WORD'(noise_q);
        REG_STATUS:  apb.PRDATA = AMBA_WORD'({ovf, fifo_full, fifo_empty, 5'(fifo_count)});
`ifdef ERR_STATS_EN
        REG_CNT1:    apb.PRDATA = AMBA_WORD'(cnt1);
        REG_CNT2:    apb.PRDATA = AMBA_WORD'(cnt2);
`else
        REG_CNT1, REG_CNT2: apb.PRDATA = '0;
`endif
        default:     apb.PRDATA = '0;
      endcase
    end
  end

  // Address bits outside [4:2] and write-data bits above the codeword are
  // intentionally ignored.
  logic unused_apb;
  assign unused_apb = ^{apb.PADDR, apb.PWDATA};

endmodule

// File: tb/tb_ecc_enc_dec_pipe.sv
// tb_ecc_enc_dec_pipe: directed bench for ecc_enc_dec_pipe at N=8, depth 4.
module tb_ecc_enc_dec_pipe;
  localparam int N     = 8;
  localparam int K     = 4;
  localparam int M     = 3;
  localparam int DEPTH = 4;

  localparam logic [19:0] A_CTRL   = 20'h00;
  localparam logic [19:0] A_DATA   = 20'h04;
  localparam logic [19:0] A_NOISE  = 20'h08;
  localparam logic [19:0] A_STATUS = 20'h0C;
  localparam logic [19:0] A_CNT1   = 20'h10;
  localparam logic [19:0] A_CNT2   = 20'h14;
  localparam logic [19:0] A_UNMAP  = 20'h18;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ecc_enc_dec_pipe_if #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) apb ();
  logic [31:0] data_out;
  logic        operation_done;
  logic [1:0]  err_num;

  ecc_enc_dec_pipe #(
    .AMBA_WORD       (32),
    .AMBA_ADDR_WIDTH (20),
    .CODE_WIDTH      (N),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst_n),
    .apb            (apb),
    .data_out       (data_out),
    .operation_done (operation_done),
    .err_num        (err_num)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp;
  int          n_fail;
  logic [33:0] exp_q[$];   // {err_num, data_out}
  int          m_en;
  int          m_mode;
  logic [N-1:0] m_noise;
  int          m_count;
  logic        m_ovf;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (positional Hamming) ----------------
  function automatic logic [N-1:0] model_encode(input logic [K-1:0] d);
    logic [N-1:0] pv;
    logic [N-1:0] cw;
    int idx;
    int syn;
    pv = '0; idx = 0; syn = 0;
    for (int p = 1; p < N; p++) if ((p & (p - 1)) != 0) begin pv[p] = d[idx]; idx++; end
    for (int p = 1; p < N; p++) if (pv[p]) syn = syn ^ p;
    for (int j = 0; j < M; j++) pv[1 << j] = ((syn >> j) & 1) == 1;
    cw = '0;
    for (int i = 0; i < K; i++) cw[i] = d[i];
    for (int j = 0; j < M; j++) cw[K+j] = pv[1 << j];
    cw[N-1] = ^cw[N-2:0];
    return cw;
  endfunction

  function automatic logic [K+1:0] model_decode(input logic [N-1:0] cw);
    logic [N-1:0] pv;
    logic [K-1:0] d;
    logic [1:0]   err;
    int idx;
    int syn;
    pv = '0; idx = 0; syn = 0;
    for (int p = 1; p < N; p++) if ((p & (p - 1)) != 0) begin pv[p] = cw[idx]; idx++; end
    for (int j = 0; j < M; j++) pv[1 << j] = cw[K+j];
    for (int p = 1; p < N; p++) if (pv[p]) syn = syn ^ p;
    if (^cw) begin
      err = 2'd1;
      if (syn != 0) pv[syn] = ~pv[syn];
    end else if (syn != 0) begin
      err = 2'd2;
    end else begin
      err = 2'd0;
    end
    idx = 0;
    for (int p = 1; p < N; p++) if ((p & (p - 1)) != 0) begin d[idx] = pv[p]; idx++; end
    return {err, d};
  endfunction

  function automatic logic [33:0] model_result(input logic [N-1:0] word);
    logic [K+1:0] r;
    case (m_mode)
      1: begin
        r = model_decode(word);
        return {r[K+1:K], 32'(r[K-1:0])};
      end
      2: begin
        r = model_decode(model_encode(word[K-1:0]) ^ m_noise);
        return {r[K+1:K], 32'(r[K-1:0])};
      end
      default: return {2'd0, 32'(model_encode(word[K-1:0]))};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apb_write(input logic [19:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = addr; apb.PWDATA = data; apb.PENABLE = 1'b0;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [19:0] addr, output logic [31:0] data);
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PWRITE = 1'b0; apb.PADDR = addr; apb.PENABLE = 1'b0;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    #1 data = apb.PRDATA;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [19:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    apb_read(addr, v);
    check(name, {2'b0, v}, {2'b0, exp});
  endtask

  task automatic set_ctrl(input int en, input int mode);
    apb_write(A_CTRL, 32'((mode << 1) | en));
    m_en = en;
    m_mode = mode;
    if (en != 0) m_count = 0;
  endtask

  task automatic set_noise(input logic [N-1:0] nz);
    apb_write(A_NOISE, 32'(nz));
    m_noise = nz;
  endtask

  task automatic push_word(input logic [N-1:0] word);
    apb_write(A_DATA, 32'(word));
    if (m_en == 0 && m_count == DEPTH) begin
      m_ovf = 1'b1;
    end else begin
      exp_q.push_back(model_result(word));
      if (m_en == 0) m_count++;
    end
  endtask

  // Push with EN=1 and check latency and literal result of the single word
  task automatic push_and_check(input string name, input logic [N-1:0] word,
                                input logic [31:0] exp_d, input logic [1:0] exp_e);
    int found;
    logic [31:0] got_d;
    logic [1:0]  got_e;
    found = -1; got_d = '0; got_e = '0;
    push_word(word);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (operation_done && found < 0) begin
        found = i; got_d = data_out; got_e = err_num;
      end
    end
    check({name, "_latency"}, 34'(found), 34'd2);
    check({name, "_data"}, {2'b0, got_d}, {2'b0, exp_d});
    check({name, "_err"}, {32'b0, got_e}, {32'b0, exp_e});
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n && operation_done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: actual done with data_out 0x%0h, required no done", data_out);
      end else begin
        check("model_out", {err_num, data_out}, exp_q.pop_front());
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] pat;
    int n_done;
    n_cmp = 0; n_fail = 0;
    m_en = 0; m_mode = 0; m_noise = '0; m_count = 0; m_ovf = 1'b0;
    rst_n = 1'b0;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;

    // Pin the model with hand-computed codewords
    check("pin_enc_B",   34'(model_encode(4'hB)), 34'h1B);
    check("pin_enc_5",   34'(model_encode(4'h5)), 34'h55);
    check("pin_dec_1A",  34'(model_decode(8'h1A)), {28'b0, 2'd1, 4'hB});
    check("pin_dec_18",  34'(model_decode(8'h18)), {28'b0, 2'd2, 4'h8});
    check("pin_dec_9B",  34'(model_decode(8'h9B)), {28'b0, 2'd1, 4'hB});

    // Reset state
    #12;
    apb.PSEL = 1'b1; apb.PADDR = A_STATUS;
    #1;
    check("rst_prdata", {2'b0, apb.PRDATA}, 34'h0);
    check("rst_data_out", {2'b0, data_out}, 34'h0);
    check("rst_done", 34'(operation_done), 34'h0);
    check("rst_err", 34'(err_num), 34'h0);
    apb.PSEL = 1'b0;
    #10 rst_n = 1'b1;

    read_check("status_idle", A_STATUS, 32'h20);
    read_check("ctrl_idle", A_CTRL, 32'h0);
    read_check("unmapped", A_UNMAP, 32'h0);

    // Single-word directed vectors
    set_ctrl(1, 0);
    push_and_check("enc_B", 8'h0B, 32'h1B, 2'd0);
    set_ctrl(1, 3);
    read_check("ctrl_readback", A_CTRL, 32'h7);
    push_and_check("rsvd_enc_5", 8'h05, 32'h55, 2'd0);
    set_noise(8'h01);
    set_ctrl(1, 2);
    push_and_check("full_n01", 8'h0B, 32'hB, 2'd1);
    set_noise(8'h03);
    push_and_check("full_n03", 8'h0B, 32'h8, 2'd2);
    read_check("noise_readback", A_NOISE, 32'h03);
    set_ctrl(1, 1);
    push_and_check("dec_9B", 8'h9B, 32'hB, 2'd1);
    push_and_check("dec_1B", 8'h1B, 32'hB, 2'd0);
    push_and_check("dec_2B", 8'h2B, 32'hB, 2'd2);

    // Queue while disabled, overflow, then drain back-to-back
    set_ctrl(0, 0);
    push_word(8'h03);
    push_word(8'h05);
    push_word(8'h0A);
    push_word(8'h0F);
    push_word(8'h06);
    read_check("status_full_ovf", A_STATUS, 32'hC4);
    read_check("data_in_head", A_DATA, 32'h03);
    set_ctrl(1, 0);
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat[i] = operation_done;
    end
    check("b2b_done_pattern", 34'(pat), 34'h3C);
    read_check("status_drained", A_STATUS, 32'hA0);
    apb_write(A_STATUS, 32'h0);
    read_check("status_ovf_clr", A_STATUS, 32'h20);
    read_check("data_in_empty", A_DATA, 32'h0);

`ifdef ERR_STATS_EN
    read_check("cnt1", A_CNT1, 32'd2);
    read_check("cnt2", A_CNT2, 32'd2);
    apb_write(A_CNT2, 32'h0);
    read_check("cnt1_clr", A_CNT1, 32'd0);
`else
    read_check("cnt1_absent", A_CNT1, 32'h0);
    read_check("cnt2_absent", A_CNT2, 32'h0);
`endif

    // Reset mid-stream: no done pulses may follow
    set_ctrl(0, 0);
    apb_write(A_DATA, 32'h01);
    apb_write(A_DATA, 32'h02);
    apb_write(A_CTRL, 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_data_out", {2'b0, data_out}, 34'h0);
    check("midrst_done", 34'(operation_done), 34'h0);
    check("midrst_err", 34'(err_num), 34'h0);
    apb.PSEL = 1'b1; apb.PWRITE = 1'b0; apb.PADDR = A_STATUS;
    #1;
    check("midrst_prdata", {2'b0, apb.PRDATA}, 34'h0);
    apb.PSEL = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    m_en = 0; m_mode = 0; m_noise = '0; m_count = 0; m_ovf = 1'b0;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (operation_done) n_done++;
    end
    check("post_rst_no_done", 34'(n_done), 34'h0);
    read_check("post_rst_status", A_STATUS, 32'h20);
    read_check("post_rst_ctrl", A_CTRL, 32'h0);
`ifdef ERR_STATS_EN
    read_check("post_rst_cnt1", A_CNT1, 32'h0);
    read_check("post_rst_cnt2", A_CNT2, 32'h0);
`endif

    check("exp_q_drained", 34'(exp_q.size()), 34'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_enc_dec_pipe.md
Name: ecc_enc_dec_pipe

Overview:
- Parametrised, pipelined successor to the ecc_enc_dec APB codec.
- Extended-Hamming SECDED encode, decode and full-channel (encode, then noise injection, then decode) over a configurable codeword width.
- Input words are queued in a FIFO, and the pipeline sustains one word per cycle.
- Sits behind the same APB slave port as ecc_enc_dec and drives data_out, operation_done and err_num to the system.

Parameters:
- AMBA_WORD, 32: APB data width.
- AMBA_ADDR_WIDTH, 20: APB address width.
- CODE_WIDTH, 32: codeword bits N. Legal values are 8, 16, 32. Data bits K = N-log2(N)-1 (4/11/26).
- FIFO_DEPTH, 4: input queue entries, power of two, 2..16.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- PADDR  in  AMBA_ADDR_WIDTH  APB address. Only bits [4:2] are decoded.
- PWRITE  in  1  APB write.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWDATA  in  AMBA_WORD  APB write data.
- PRDATA  out  AMBA_WORD  APB read data.
- data_out  out  AMBA_WORD  result word, zero-extended.
- operation_done  out  1  one-cycle pulse per completed word.
- err_num  out  2  0 = no error, 1 = single error (corrected), 2 = double error (detected).

Behaviour:
- Reset (rst=0, async):
  - FIFO is emptied; pipeline valids, CTRL, NOISE and the OVF flag are cleared.
  - data_out=0, operation_done=0, err_num=0, PRDATA=0.
  - A word in flight when reset asserts is discarded and produces no done pulse.
- APB:
  - Write commits when PSEL&PENABLE&PWRITE.
  - PRDATA is combinational from registers when PSEL&!PWRITE, otherwise 0. No wait states.
  - Unmapped offsets read 0 and ignore writes.
- Registers:
  - 0x00 CTRL: [0] EN, [2:1] MODE (0 = encode, 1 = decode, 2 = full, 3 = reserved and treated as encode).
  - 0x04 DATA_IN: write pushes PWDATA[N-1:0] to the FIFO. Read returns the FIFO head, or 0 if empty.
  - 0x08 NOISE: N-bit XOR mask, used in full mode only.
  - 0x0C STATUS (read-only): [4:0] count, [5] empty, [6] full, [7] OVF sticky. Writing any value clears OVF.
- FIFO:
  - Push with count==FIFO_DEPTH and no pop in the same cycle: the push is dropped and OVF is set.
  - Push and pop in the same cycle while full: both take effect and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Pop: occurs when EN=1 and the FIFO is non-empty, one word per cycle. MODE and NOISE are sampled at pop and travel with the word.
- Stage 1 (cycle after pop):
  - Encode mode: data[K-1:0] becomes the codeword.
  - Decode mode: the input word is taken as the codeword.
  - Full mode: the encoded word is XORed with NOISE.
- Stage 2: decode and register outputs. operation_done is high 2 cycles after the pop cycle.
  - Back-to-back pops give back-to-back done pulses.
  - data_out holds its value between pulses.
- Codeword layout (systematic):
  - Bits [K-1:0] are data. Data bit i maps to the i-th non-power-of-two Hamming position (3,5,6,7,9,...).
  - Bits [N-2:K] are parity p0..p(m-1). pj is the XOR of data bits whose position has bit j set.
  - Bit N-1 is overall parity of bits [N-2:0].
- Decode classification (syndrome s over p, overall-parity mismatch o):
  - s=0, o=0: err_num=0.
  - o=1: err_num=1. Correct the bit at position s; s=0 means the overall-parity bit itself flipped.
  - s!=0, o=0: err_num=2. data_out is the uncorrected data field.
- data_out per mode:
  - Encode: the codeword, err_num=0.
  - Decode and full: corrected data bits [K-1:0].
- Clearing EN mid-stream: stops further pops; words already in the pipeline complete.

Optional Feature:
- Macro ERR_STATS_EN.
- Defined:
  - 0x10 CNT1 and 0x14 CNT2 are 16-bit saturating counters of err_num=1 and err_num=2 events, counted on operation_done.
  - A write to either register clears both.
  - A count event coinciding with a clear leaves the counter at 0.
- Undefined: 0x10 and 0x14 read 0, and no counter flops exist.

Decomposition:
- Package ecc_pkg:
  - register offsets
  - MODE encodings
  - err_num encodings
  - constant functions for K(N), m(N) and parity coverage masks per parity bit
- Sub-module ecc_sync_fifo: parametrised width/depth, push/pop/full/empty/count.
- Encode/decode logic stays in the top as functions.

Test Plan:
- N=8, MODE=0, EN=1, write DATA_IN=0xB -> data_out=0x1B, err_num=0, done 2 cycles after pop.
- N=8, MODE=2, NOISE=0x01, DATA_IN=0xB -> data_out=0xB, err_num=1.
- N=8, MODE=2, NOISE=0x03, DATA_IN=0xB -> data_out=0x8, err_num=2.
- N=8, MODE=1, DATA_IN=0x9B (overall bit flipped) -> data_out=0xB, err_num=1.
- EN=0, 5 pushes with FIFO_DEPTH=4 -> STATUS=0x44 (count 4, full) plus OVF, i.e. 0xC4. Set EN -> 4 consecutive done pulses, then STATUS empty=1.
- Assert rst mid-stream with 2 words queued -> all outputs 0 immediately, no further done pulses. With ERR_STATS_EN, CNT1 and CNT2 read 0.
